ps2_key_writer: RTL and testbench
=================================

Name: ps2_key_writer

Overview:
- PS/2 keyboard receiver and make-code filter that produces the write stream for the scancode-to-ASCII character buffer: `we`, `inaddr`, `din`.
- Samples the raw PS/2 clock and data lines, checks each 11-bit frame, and buffers good bytes in a small FIFO.
- Drops break and extended sequences.
- Emits one single-cycle write per key press, at a monotonically advancing 8-bit buffer address.

Parameters:
- FIFO_DEPTH, 8, number of received-byte entries (power of 2, at least 2).
- TIMEOUT, 16'd50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- hold  in  1  consumer busy; while high, no write is issued.
- we  out  1  one-cycle write strobe to the character buffer.
- inaddr  out  8  buffer address of the current write.
- din  out  8  scancode being written.
- parity_err  out  1  one-cycle pulse on a bad-parity or bad-stop frame.
- overflow  out  1  sticky; set when a good byte arrives while the FIFO is full.

Behaviour:
- Reset (asynchronous, any state) clears all of the following:
  - outputs: we=0, inaddr=8'h00, din=8'h00, parity_err=0, overflow=0;
  - FIFO: empty;
  - receiver: idle, bit count 0, timeout counter 0;
  - filter FSM: S_IDLE;
  - synchronisers: loaded with 1.
- Synchronisation:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - A falling edge is a sampled sync'd ps2_clk transition from 1 to 0 (3rd flop for history).
  - All frame bits are sampled on that edge.
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1).
  - At bit count 0, a start bit of 1 is ignored (no state change).
  - At the 11th bit, the frame is good when XOR(d[7:0], parity)=1 and stop=1.
  - Good frame: push the byte to the FIFO, with the push cycle being the edge+1 cycle.
  - Bad frame: parity_err=1 for exactly one cycle; nothing is pushed.
  - In either case, bit count returns to 0.
- Timeout:
  - While bit count is non-zero, a counter increments every clk and resets on each falling edge.
  - On reaching TIMEOUT the frame is aborted: bit count returns to 0, with no push and no error pulse.
- FIFO: synchronous, with read/write pointers one bit wider than the index.
  - Push while full: the byte is dropped and overflow is set; overflow clears only on reset.
  - Simultaneous push and pop when full is still a drop, because push is evaluated before pop.
- Filter FSM: pops at most one byte per clk, and only when the FIFO is non-empty.
  - S_IDLE:
    - byte F0 goes to S_BRK;
    - byte E0 goes to S_EXT;
    - any other byte is emitted.
  - S_EXT:
    - F0 goes to S_BRK;
    - E0 stays in S_EXT;
    - any other byte is discarded (extended make) and the FSM returns to S_IDLE.
  - S_BRK: the next byte is discarded and the FSM returns to S_IDLE.
  - In S_IDLE, when the head byte is to be emitted and hold=1, that byte is not popped and the FSM waits.
- Emission:
  - The cycle after the pop: we=1, din=byte, inaddr=current address.
  - The cycle after that: we=0, and the address increments by 1, wrapping 8'hFF to 8'h00.
  - inaddr and din hold their values between writes.
  - Minimum spacing between we pulses is 2 cycles.
- Latency: the emission we pulse follows the final (stop-bit) falling edge by 3 clk when the FIFO is empty and hold=0.

Test Plan:
- Single key press:
  - Stimulus: frame for 8'h1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), hold=0.
  - Response: one we pulse with din=8'h1C and inaddr=8'h00; inaddr reads 8'h01 at the next write.
- Key release:
  - Stimulus: frames 1C, F0, 1C, 32.
  - Response: exactly two writes, din=1C at addr 00 and din=32 at addr 01; no write for the F0-1C pair.
- Extended and error frames:
  - Stimulus: frames E0 75, E0 F0 75, then 1C sent with parity=1.
  - Response: no we; parity_err pulses exactly once; FIFO stays empty; the FSM ends in S_IDLE.
- Backpressure and overflow:
  - Stimulus: hold=1, send 9 distinct make codes 15,1D,24,2D,2C,35,3C,43,44, then set hold=0.
  - Response: overflow=1; 8 writes in order 15..43; code 44 is lost.
- Timeout and wrap:
  - Stimulus, part 1: send 5 bits, go silent for TIMEOUT+10 cycles, then send a full 8'h1C frame.
  - Response, part 1: a single write with din=1C.
  - Stimulus, part 2: 256 consecutive make codes.
  - Response, part 2: inaddr reaches 8'hFF, and the next write lands at 8'h00.
- Asynchronous reset mid-frame:
  - Stimulus: assert rst after 6 bits of a frame, then send a clean 8'h1C frame.
  - Response: all outputs are 0 immediately on rst; after release, one write with din=1C at inaddr=8'h00.

Source files
------------

// File: rtl/ps2_key_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_writer_if
// Purpose  : Write-side bus from the key writer into the character buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_writer_if;
  logic       we;
  logic [7:0] inaddr;
  logic [7:0] din;
  logic       hold;

  modport master (output we, output inaddr, output din, input hold);
  modport slave  (input we, input inaddr, input din, output hold);
endinterface
`default_nettype wire

// File: rtl/ps2_key_writer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_writer
// Purpose  : PS/2 frame receiver, byte FIFO and make-code filter that issues
//            one buffer write per key press.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            ps2_clk,
  input  wire logic            ps2_data,
  ps2_key_writer_if.master     wr,
  output      logic            parity_err,
  output      logic            overflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  BRK_CODE = 8'hF0;
  localparam logic [7:0]  EXT_CODE = 8'hE0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_BRK  = 2'd2;

  logic        r_clk_s1, r_clk_s2, r_clk_s3;
  logic        r_dat_s1, r_dat_s2;
  logic        w_fall;

  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [15:0] r_tcnt;
  logic        r_push;
  logic [7:0]  r_push_byte;
  logic        r_perr;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_ovf;
  logic        w_empty, w_full;
  logic [7:0]  w_head;

  logic [1:0]  r_state, w_next;
  logic        w_avail, w_pop, w_emit;
  logic        r_we;
  logic [7:0]  r_din, r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;

  // Bit count 1..8 collects data LSB first, 9 takes parity, 10 judges the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_tcnt      <= 16'd0;
      r_push      <= 1'b0;
      r_push_byte <= 8'h00;
      r_perr      <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_perr <= 1'b0;
      if (w_fall) begin
        r_tcnt <= 16'd0;
        if (r_bitcnt == 4'd0) begin
          if (!r_dat_s2) r_bitcnt <= 4'd1;
        end else if (r_bitcnt <= 4'd8) begin
          r_shift  <= {r_dat_s2, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end else if (r_bitcnt == 4'd9) begin
          r_par    <= r_dat_s2;
          r_bitcnt <= 4'd10;
        end else begin
          if ((^r_shift ^ r_par) && r_dat_s2) begin
            r_push      <= 1'b1;
            r_push_byte <= r_shift;
          end else begin
            r_perr <= 1'b1;
          end
          r_bitcnt <= 4'd0;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_tcnt == TIMEOUT) begin
          r_bitcnt <= 4'd0;
          r_tcnt   <= 16'd0;
        end else begin
          r_tcnt <= r_tcnt + 16'd1;
        end
      end else begin
        r_tcnt <= 16'd0;
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_push) begin
        if (w_full) r_ovf  <= 1'b1;
        else        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (r_push && !w_full) r_mem[r_wptr[AW-1:0]] <= r_push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // The filter stalls during the write cycle so the address bumps before the next write.
  assign w_avail = !w_empty && !r_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_avail) begin
          if (w_head == BRK_CODE)      w_next = S_BRK;
          else if (w_head == EXT_CODE) w_next = S_EXT;
        end
      end
      S_EXT: begin
        if (w_avail) begin
          if (w_head == BRK_CODE)      w_next = S_BRK;
          else if (w_head == EXT_CODE) w_next = S_EXT;
          else                         w_next = S_IDLE;
        end
      end
      S_BRK: begin
        if (w_avail) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_emit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_avail) begin
          if (w_head == BRK_CODE || w_head == EXT_CODE) begin
            w_pop = 1'b1;
          end else if (!wr.hold) begin
            w_pop  = 1'b1;
            w_emit = 1'b1;
          end
        end
      end
      S_EXT, S_BRK: w_pop = w_avail;
      default: begin
        w_pop  = 1'b0;
        w_emit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_din  <= 8'h00;
      r_addr <= 8'h00;
    end else begin
      r_we <= w_emit;
      if (w_emit) r_din  <= w_head;
      if (r_we)   r_addr <= r_addr + 8'd1;
    end
  end

  assign wr.we      = r_we;
  assign wr.inaddr  = r_addr;
  assign wr.din     = r_din;
  assign parity_err = r_perr;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_writer
// Purpose  : Directed PS/2 frames against a queue-based key-filter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_writer;

  localparam int          DEPTH = 8;
  localparam logic [15:0] TO    = 16'd300;
  localparam int          HALF  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic parity_err, overflow;

  ps2_key_writer_if wr_if ();

  ps2_key_writer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .wr         (wr_if),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: received bytes, filter mode (0 plain, 1 after E0, 2 after F0), expected writes.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_mode = 0;
  bit         m_hold = 1'b0;
  bit         m_ovf  = 1'b0;
  int         m_perr = 0;
  logic [7:0] exp_addr = 8'h00;

  function automatic void m_drain();
    logic [7:0] b;
    while (m_q.size() > 0) begin
      b = m_q[0];
      if (m_mode == 0) begin
        if (b == 8'hF0)      m_mode = 2;
        else if (b == 8'hE0) m_mode = 1;
        else if (m_hold)     break;
        else                 exp_q.push_back(b);
      end else if (m_mode == 1) begin
        if (b == 8'hF0)      m_mode = 2;
        else if (b != 8'hE0) m_mode = 0;
      end else begin
        m_mode = 0;
      end
      void'(m_q.pop_front());
    end
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_perr++;
    end else begin
      m_drain();
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else                     m_q.push_back(b);
      m_drain();
    end
  endfunction

  int         wr_count  = 0;
  int         perr_seen = 0;
  logic [7:0] last_din  = 8'h00;
  logic [7:0] last_addr = 8'h00;
  bit         prev_we   = 1'b0;
  bit         saw_ff    = 1'b0;
  bit         wrap_ok   = 1'b0;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (parity_err) perr_seen++;
        if (wr_if.we) begin
          check("we_spacing", int'(prev_we), 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got din=%0h addr=%0h expected no write",
                     wr_if.din, wr_if.inaddr);
          end else begin
            e = exp_q.pop_front();
            check("write_din", int'(wr_if.din), int'(e));
            check("write_addr", int'(wr_if.inaddr), int'(exp_addr));
            exp_addr++;
          end
          if (saw_ff && wr_if.inaddr == 8'h00) wrap_ok = 1'b1;
          saw_ff    = (wr_if.inaddr == 8'hFF);
          wr_count++;
          last_din  = wr_if.din;
          last_addr = wr_if.inaddr;
        end
        prev_we = wr_if.we;
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit v);
    ps2_data = v;
    clk_wait(HALF);
    ps2_clk = 1'b0;
    clk_wait(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    bit p;
    p = (~^b) ^ bad;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_data = 1'b1;
    clk_wait(HALF);
    ps2_clk = 1'b0;
    m_frame(b, !bad);
    clk_wait(HALF);
    ps2_clk = 1'b1;
    clk_wait(12);
  endtask

  task automatic send_bits(input int n, input logic [7:0] b);
    ps2_bit(1'b0);
    for (int i = 0; i < n - 1; i++) ps2_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, int'(wr_if.we), 0);
    check({tag, "_inaddr"}, int'(wr_if.inaddr), 0);
    check({tag, "_din"}, int'(wr_if.din), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] code;
    logic [7:0] presses [9];
    presses = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    wr_if.hold = 1'b0;
    clk_wait(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    clk_wait(3);

    // Single key press
    send_frame(8'h1C, 1'b0);
    clk_wait(10);
    check("single_count", wr_count, 1);
    check("single_din", int'(last_din), 'h1C);
    check("single_addr", int'(last_addr), 'h00);
    check("single_next_addr", int'(wr_if.inaddr), 'h01);

    // Key release: F0 1C pair is swallowed
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    clk_wait(10);
    check("release_count", wr_count, 3);
    check("release_din", int'(last_din), 'h32);
    check("release_addr", int'(last_addr), 'h02);

    // Extended make, extended break, bad parity
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h1C, 1'b1);
    clk_wait(10);
    check("ext_count", wr_count, 3);
    check("ext_perr", perr_seen, 1);
    check("ext_pending", exp_q.size(), 0);

    // Backpressure and overflow
    wr_if.hold = 1'b1;
    m_hold = 1'b1;
    for (int i = 0; i < 9; i++) send_frame(presses[i], 1'b0);
    check("hold_no_write", wr_count, 3);
    check("hold_overflow", int'(overflow), 1);
    wr_if.hold = 1'b0;
    m_hold = 1'b0;
    m_drain();
    clk_wait(30);
    check("drain_count", wr_count, 11);
    check("drain_last_din", int'(last_din), 'h43);
    check("drain_last_addr", int'(last_addr), 'h0A);
    check("drain_pending", exp_q.size(), 0);
    check("overflow_model", int'(overflow), int'(m_ovf));

    // Timeout of a partial frame
    send_bits(5, 8'hAA);
    clk_wait(int'(TO) + 10);
    send_frame(8'h1C, 1'b0);
    clk_wait(10);
    check("timeout_count", wr_count, 12);
    check("timeout_din", int'(last_din), 'h1C);
    check("timeout_addr", int'(last_addr), 'h0B);
    check("timeout_perr", perr_seen, m_perr);

    // Asynchronous reset mid-frame
    send_bits(6, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    m_q.delete();
    exp_q.delete();
    m_mode   = 0;
    m_ovf    = 1'b0;
    exp_addr = 8'h00;
    clk_wait(5);
    rst = 1'b0;
    clk_wait(3);
    send_frame(8'h1C, 1'b0);
    clk_wait(10);
    check("post_rst_count", wr_count, 13);
    check("post_rst_din", int'(last_din), 'h1C);
    check("post_rst_addr", int'(last_addr), 'h00);
    check("post_rst_overflow", int'(overflow), 0);

    // Address wrap
    for (int k = 0; k < 256; k++) begin
      code = 8'(k);
      if (code == 8'hF0 || code == 8'hE0) code = 8'h11;
      send_frame(code, 1'b0);
    end
    clk_wait(10);
    check("wrap_seen", int'(wrap_ok), 1);
    check("wrap_count", wr_count, 269);
    check("wrap_last_addr", int'(last_addr), 'h00);
    check("wrap_pending", exp_q.size(), 0);
    check("final_perr", perr_seen, m_perr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
